// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared state encoding and default sizing for the frame capture sequencer
package frame_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SERVE   = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    localparam int FRAME_WORDS_DEF    = 19200;
    localparam int TIMEOUT_CYCLES_DEF = 16777216;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with asynchronous active-low reset
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/frame_capture_seq.sv
// rtl/frame_capture_seq.sv - arms a CCD capture, then serves the frame word-by-word to the HPS strobe handshake
// Optional watchdog on ARM/CAPTURE enabled by defining FRAME_SEQ_TIMEOUT_EN.
module frame_capture_seq
    import frame_seq_pkg::*;
#(
    parameter int FRAME_WORDS    = FRAME_WORDS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iCAP_REQ,
    input  logic        iFVAL,
    input  logic        iHPS_STB,
    input  logic [15:0] iFIFO_DATA,
    input  logic        iFIFO_EMPTY,
    output logic        oFIFO_RD,
    output logic        oSTART,
    output logic        oEND,
    output logic [15:0] oDATA,
    output logic        oACK,
    output logic [14:0] oWORD_CNT,
    output logic [2:0]  oSTATE,
    output logic        oDONE,
    output logic        oOVR,
    output logic        oTMO
);

    localparam logic [14:0] FW_MAX  = 15'(FRAME_WORDS);
    localparam logic [14:0] FW_LAST = 15'(FRAME_WORDS - 1);

    logic cap_s, stb_s;

    sync2 u_sync_cap (.clk(iCLK), .rst_n(iRST_N), .d(iCAP_REQ), .q(cap_s));
    sync2 u_sync_stb (.clk(iCLK), .rst_n(iRST_N), .d(iHPS_STB), .q(stb_s));

    seq_state_e  state_q, state_d;
    logic        cap_prev_q, cap_prev_d;
    logic        stb_prev_q, stb_prev_d;
    logic [1:0]  ref_cnt_q, ref_cnt_d;
    logic        seen_low_q, seen_low_d;
    logic        pending_q, pending_d;
    logic        rd_q, rd_d;
    logic [15:0] data_q, data_d;
    logic        ack_q, ack_d;
    logic [14:0] cnt_q, cnt_d;
    logic        start_q, start_d;
    logic        end_q, end_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        pend_next;

    logic cap_rise, ref_ok, toggle, take, last_word, abort, arm_entry, tmo_fire;

    // The strobe reference is only trusted once the synchroniser has refilled after reset.
    assign ref_ok    = (ref_cnt_q == 2'd3);
    assign cap_rise  = cap_s && !cap_prev_q;
    assign toggle    = ref_ok && (stb_s != stb_prev_q);
    assign take      = (state_q == ST_SERVE) && rd_q;
    assign last_word = take && (cnt_q == FW_LAST);
    assign abort     = !cap_s && (state_q inside {ST_ARM, ST_CAPTURE, ST_SERVE});
    assign arm_entry = (state_q == ST_IDLE) && (state_d == ST_ARM);

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;
    logic             waiting;

    assign waiting  = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
    assign tmo_fire = waiting && !abort && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = (waiting && (state_d == state_q)) ? tmo_cnt_q + TMO_W'(1) : '0;
        tmo_d     = tmo_q;
        if (arm_entry) tmo_d = 1'b0;
        if (tmo_fire)  tmo_d = 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign oTMO = tmo_q;
`else
    logic unused_tmo_param;
    assign unused_tmo_param = (TIMEOUT_CYCLES == 0);
    assign tmo_fire         = 1'b0;
    assign oTMO             = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            cap_prev_q <= 1'b0;
            stb_prev_q <= 1'b0;
            ref_cnt_q  <= 2'd0;
            seen_low_q <= 1'b0;
            pending_q  <= 1'b0;
            rd_q       <= 1'b0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_prev_q <= cap_prev_d;
            stb_prev_q <= stb_prev_d;
            ref_cnt_q  <= ref_cnt_d;
            seen_low_q <= seen_low_d;
            pending_q  <= pending_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            end_q      <= end_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cap_rise) state_d = ST_ARM;
            ST_ARM:     if (abort || tmo_fire) state_d = ST_IDLE;
                        else if (seen_low_q && iFVAL) state_d = ST_CAPTURE;
            ST_CAPTURE: if (abort || tmo_fire) state_d = ST_IDLE;
                        else if (!iFVAL) state_d = ST_SERVE;
            ST_SERVE:   if (abort) state_d = ST_IDLE;
                        else if (last_word) state_d = ST_DONE;
            ST_DONE:    if (!cap_s) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cap_prev_d = cap_s;
        stb_prev_d = stb_s;
        ref_cnt_d  = ref_ok ? ref_cnt_q : ref_cnt_q + 2'd1;
        seen_low_d = (state_q == ST_ARM) && (seen_low_q || !iFVAL);
        start_d    = (state_q == ST_ARM) && (state_d == ST_CAPTURE);
        end_d      = ((state_q == ST_CAPTURE) && (state_d != ST_CAPTURE)) || tmo_fire;
        done_d     = (state_d == ST_DONE);
        data_d     = data_q;
        ack_d      = ack_q;
        cnt_d      = cnt_q;
        ovr_d      = ovr_q;
        pend_next  = 1'b0;
        pending_d  = 1'b0;
        rd_d       = 1'b0;
        if (arm_entry) begin
            cnt_d = '0;
            ovr_d = 1'b0;
        end
        if ((state_q == ST_SERVE) && !abort) begin
            pend_next = pending_q && !take;
            if (take && (cnt_q != FW_MAX)) begin
                data_d = iFIFO_DATA;
                ack_d  = !ack_q;
                cnt_d  = cnt_q + 15'd1;
            end
            // A strobe that lands before the previous request is answered is dropped.
            if (toggle) begin
                if (pending_q) ovr_d = 1'b1;
                else           pend_next = 1'b1;
            end
            pending_d = pend_next && !last_word;
            rd_d      = pending_d && !rd_q && !iFIFO_EMPTY;
        end
    end

    assign oFIFO_RD  = rd_q;
    assign oSTART    = start_q;
    assign oEND      = end_q;
    assign oDATA     = data_q;
    assign oACK      = ack_q;
    assign oWORD_CNT = cnt_q;
    assign oSTATE    = state_q;
    assign oDONE     = done_q;
    assign oOVR      = ovr_q;

endmodule

// File: tb/tb_frame_capture_seq.sv
// tb/tb_frame_capture_seq.sv - randomized self-checking bench for frame_capture_seq
module tb_frame_capture_seq;

    localparam int FW  = 4;
    localparam int TMO = 100;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iCAP_REQ = 1'b0;
    logic        iFVAL = 1'b0;
    logic        iHPS_STB = 1'b0;
    logic [15:0] iFIFO_DATA = 16'h0;
    logic        iFIFO_EMPTY = 1'b1;
    logic        oFIFO_RD, oSTART, oEND, oACK, oDONE, oOVR, oTMO;
    logic [15:0] oDATA;
    logic [14:0] oWORD_CNT;
    logic [2:0]  oSTATE;

    always #5 iCLK = ~iCLK;

    frame_capture_seq #(.FRAME_WORDS(FW), .TIMEOUT_CYCLES(TMO)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCAP_REQ(iCAP_REQ), .iFVAL(iFVAL),
        .iHPS_STB(iHPS_STB), .iFIFO_DATA(iFIFO_DATA), .iFIFO_EMPTY(iFIFO_EMPTY),
        .oFIFO_RD(oFIFO_RD), .oSTART(oSTART), .oEND(oEND), .oDATA(oDATA),
        .oACK(oACK), .oWORD_CNT(oWORD_CNT), .oSTATE(oSTATE), .oDONE(oDONE),
        .oOVR(oOVR), .oTMO(oTMO)
    );

    logic [15:0] fifo[$];
    logic [15:0] got[$];
    logic [15:0] expw[$];
    bit   hold_empty = 1'b0;
    bit   rd_prev = 1'b0;
    logic ack_prev = 1'b0;
    int   ack_count, rd_count, start_count, end_count;
    int   tests = 0;
    int   fails = 0;

    task automatic drive_fifo();
        iFIFO_EMPTY = hold_empty || (fifo.size() == 0);
        iFIFO_DATA  = (fifo.size() != 0) ? fifo[0] : 16'h0;
    endtask

    // Show-ahead FIFO model: a pop seen this cycle removes the head after the DUT has latched it.
    task automatic tick();
        @(negedge iCLK);
        if (rd_prev && fifo.size() != 0) void'(fifo.pop_front());
        rd_prev = oFIFO_RD;
        if (oFIFO_RD) rd_count++;
        if (oSTART) start_count++;
        if (oEND) end_count++;
        if (oACK !== ack_prev) begin
            ack_count++;
            got.push_back(oDATA);
        end
        ack_prev = oACK;
        drive_fifo();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        ack_count = 0; rd_count = 0; start_count = 0; end_count = 0;
        got.delete();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (oSTATE === s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (oSTATE === s) ok = 1'b1;
    endtask

    task automatic start_frame(output bit ok);
        bit a, c, s;
        iCAP_REQ = 1'b1;
        iFVAL = 1'b0;
        wait_state(3'd1, 20, a);
        ticks($urandom_range(1, 5));
        iFVAL = 1'b1;
        wait_state(3'd2, 10, c);
        ticks($urandom_range(2, 6));
        iFVAL = 1'b0;
        wait_state(3'd3, 10, s);
        ok = a && c && s;
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        ticks(2);
        tests++; if (oSTATE !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", oSTATE); end
        tests++; if (oDATA !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0", oDATA); end
        tests++; if (oACK !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", oACK); end
        tests++; if (oWORD_CNT !== 15'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", oWORD_CNT); end
        tests++; if ({oDONE, oOVR, oTMO} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {oDONE, oOVR, oTMO}); end
        tests++; if ({oFIFO_RD, oSTART, oEND} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b want 000", {oFIFO_RD, oSTART, oEND}); end
        iRST_N = 1'b1;
        ticks(5);
        tests++; if (oSTATE !== 3'd0) begin fails++; $display("FAIL post_reset_idle got %0d want 0", oSTATE); end
    endtask

    task automatic test_full_frame();
        bit ok;
        logic a0;
        int rc, ac;
        fifo.delete();
        for (int i = 0; i < FW; i++) fifo.push_back(16'($urandom));
        expw = fifo;
        drive_fifo();
        clear_counts();
        start_frame(ok);
        tests++; if (!ok) begin fails++; $display("FAIL frame_reach_serve state %0d want 3", oSTATE); end
        a0 = oACK;
        iHPS_STB = ~iHPS_STB;
        ticks(3);
        tests++; if (oACK !== a0) begin fails++; $display("FAIL latency_early ack %b want %b", oACK, a0); end
        tick();
        tests++; if (oACK !== ~a0) begin fails++; $display("FAIL latency_4 ack %b want %b", oACK, ~a0); end
        for (int i = 1; i < FW; i++) begin
            iHPS_STB = ~iHPS_STB;
            ticks($urandom_range(6, 12));
        end
        wait_state(3'd4, 50, ok);
        tests++; if (!ok) begin fails++; $display("FAIL frame_done_state got %0d want 4", oSTATE); end
        tests++; if (start_count != 1 || end_count != 1) begin fails++; $display("FAIL frame_pulses start %0d end %0d want 1 1", start_count, end_count); end
        tests++; if (ack_count != FW) begin fails++; $display("FAIL frame_acks got %0d want %0d", ack_count, FW); end
        for (int i = 0; i < FW; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== expw[i]) begin
                fails++;
                $display("FAIL frame_word%0d got %h want %h", i, (i < got.size()) ? got[i] : 16'hxxxx, expw[i]);
            end
        end
        tests++; if (oDONE !== 1'b1 || oWORD_CNT !== 15'(FW)) begin fails++; $display("FAIL frame_done done %b cnt %0d want 1 %0d", oDONE, oWORD_CNT, FW); end
        fifo.push_back(16'hBEEF);
        drive_fifo();
        rc = rd_count; ac = ack_count;
        iHPS_STB = ~iHPS_STB;
        ticks(8);
        tests++; if (rd_count != rc || ack_count != ac || oWORD_CNT !== 15'(FW)) begin fails++; $display("FAIL done_ignores_strobe rd %0d ack %0d cnt %0d want %0d %0d %0d", rd_count, ack_count, oWORD_CNT, rc, ac, FW); end
        iCAP_REQ = 1'b0;
        wait_state(3'd0, 10, ok);
        tests++; if (!ok || oDONE !== 1'b0) begin fails++; $display("FAIL done_exit state %0d done %b want 0 0", oSTATE, oDONE); end
    endtask

    task automatic test_empty_stall();
        bit ok;
        logic [15:0] w;
        w = 16'($urandom);
        fifo.delete();
        fifo.push_back(w);
        hold_empty = 1'b1;
        drive_fifo();
        start_frame(ok);
        clear_counts();
        iHPS_STB = ~iHPS_STB;
        ticks(10);
        tests++; if (rd_count != 0) begin fails++; $display("FAIL stall_no_pop got %0d want 0", rd_count); end
        hold_empty = 1'b0;
        drive_fifo();
        tick();
        tests++; if (oFIFO_RD !== 1'b1) begin fails++; $display("FAIL stall_pop got %b want 1", oFIFO_RD); end
        tick();
        tests++; if (ack_count != 1 || got.size() != 1 || got[0] !== w) begin fails++; $display("FAIL stall_ack acks %0d data %h want 1 %h", ack_count, oDATA, w); end
    endtask

    task automatic test_overrun();
        logic [15:0] w1, w2;
        w1 = 16'($urandom); w2 = 16'($urandom);
        fifo.push_back(w1);
        fifo.push_back(w2);
        hold_empty = 1'b1;
        drive_fifo();
        clear_counts();
        iHPS_STB = ~iHPS_STB;
        tick();
        iHPS_STB = ~iHPS_STB;
        ticks(8);
        tests++; if (oOVR !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", oOVR); end
        hold_empty = 1'b0;
        drive_fifo();
        ticks(12);
        tests++; if (ack_count != 1 || rd_count != 1) begin fails++; $display("FAIL ovr_one_word acks %0d pops %0d want 1 1", ack_count, rd_count); end
        tests++; if (got.size() != 1 || got[0] !== w1 || oWORD_CNT !== 15'd2) begin fails++; $display("FAIL ovr_data data %h cnt %0d want %h 2", oDATA, oWORD_CNT, w1); end
    endtask

    task automatic test_abort();
        bit ok, seen;
        iCAP_REQ = 1'b0;
        wait_state(3'd0, 10, ok);
        iCAP_REQ = 1'b1;
        wait_state(3'd1, 10, ok);
        tick();
        tests++; if (!ok || oOVR !== 1'b0 || oWORD_CNT !== 15'd0) begin fails++; $display("FAIL arm_clear state %0d ovr %b cnt %0d want 1 0 0", oSTATE, oOVR, oWORD_CNT); end
        iFVAL = 1'b1;
        wait_state(3'd2, 10, ok);
        clear_counts();
        iCAP_REQ = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (oEND) begin
                seen = 1'b1;
                tests++; if (oSTATE !== 3'd0 || oWORD_CNT !== 15'd0) begin fails++; $display("FAIL abort_state state %0d cnt %0d want 0 0", oSTATE, oWORD_CNT); end
            end
        end
        iFVAL = 1'b0;
        tick();
        tests++; if (!seen || end_count != 1 || oSTATE !== 3'd0) begin fails++; $display("FAIL abort_end seen %b ends %0d state %0d want 1 1 0", seen, end_count, oSTATE); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        iFVAL = 1'b0;
        iCAP_REQ = 1'b1;
        wait_state(3'd1, 10, ok);
        clear_counts();
        n = 0;
`ifdef FRAME_SEQ_TIMEOUT_EN
        while (n < 1200 && oSTATE === 3'd1) begin
            tick();
            n++;
        end
        tests++; if (n != TMO || oSTATE !== 3'd0) begin fails++; $display("FAIL tmo_cycle left ARM after %0d state %0d want %0d 0", n, oSTATE, TMO); end
        tests++; if (oTMO !== 1'b1 || end_count != 1) begin fails++; $display("FAIL tmo_flag tmo %b ends %0d want 1 1", oTMO, end_count); end
`else
        ticks(1000);
        tests++; if (!ok || oSTATE !== 3'd1) begin fails++; $display("FAIL no_tmo_wait state %0d want 1", oSTATE); end
        tests++; if (oTMO !== 1'b0) begin fails++; $display("FAIL no_tmo_flag got %b want 0", oTMO); end
`endif
        iCAP_REQ = 1'b0;
        wait_state(3'd0, 10, ok);
    endtask

    task automatic test_reset_serve();
        bit ok;
        fifo.delete();
        fifo.push_back(16'($urandom));
        hold_empty = 1'b1;
        drive_fifo();
        start_frame(ok);
        iHPS_STB = ~iHPS_STB;
        ticks(6);
        tests++; if (!ok) begin fails++; $display("FAIL rst_serve_reach state %0d want 3", oSTATE); end
        iRST_N = 1'b0;
        #1;
        tests++; if ({oSTATE, oACK, oWORD_CNT, oDATA} !== '0 || {oDONE, oOVR, oTMO, oFIFO_RD, oSTART, oEND} !== 6'b0) begin
            fails++;
            $display("FAIL rst_serve_zero state %0d ack %b cnt %0d data %h want all 0", oSTATE, oACK, oWORD_CNT, oDATA);
        end
        iCAP_REQ = 1'b0;
        iHPS_STB = 1'b1;
        ack_prev = oACK;
        rd_prev = 1'b0;
        ticks(2);
        iRST_N = 1'b1;
        hold_empty = 1'b0;
        drive_fifo();
        clear_counts();
        ticks(20);
        tests++; if (ack_count != 0 || rd_count != 0 || oSTATE !== 3'd0) begin fails++; $display("FAIL rst_serve_quiet acks %0d pops %0d state %0d want 0 0 0", ack_count, rd_count, oSTATE); end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_full_frame();
        test_empty_stall();
        test_overrun();
        test_abort();
        test_timeout();
        test_reset_serve();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_capture_seq.md
FRAME_CAPTURE_SEQ -- requirements
Module: frame_capture_seq

Interface
REQ-001 Parameter FRAME_WORDS, 19200, 16-bit packed words per frame (640*480/16).
REQ-002 Parameter TIMEOUT_CYCLES, 16777216, watchdog limit in iCLK cycles (used only with FRAME_SEQ_TIMEOUT_EN).
REQ-003 iCLK  in  1  sole clock.
REQ-004 iRST_N  in  1  reset; asynchronous, active-low.
REQ-005 iCAP_REQ  in  1  HPS capture request level; asynchronous; 2-flop synchronised.
REQ-006 iFVAL  in  1  frame valid, already in iCLK domain.
REQ-007 iHPS_STB  in  1  HPS read strobe; each toggle requests one word; asynchronous; 2-flop synchronised.
REQ-008 iFIFO_DATA  in  16  packed pixel word from SDRAM read FIFO.
REQ-009 iFIFO_EMPTY  in  1  read FIFO empty.
REQ-010 oFIFO_RD  out  1  one-cycle FIFO pop.
REQ-011 oSTART / oEND  out  1 each  one-cycle capture start/stop pulses to CCD capture.
REQ-012 oDATA  out  16  word presented to HPS.
REQ-013 oACK  out  1  toggles once per delivered word.
REQ-014 oWORD_CNT  out  15  words delivered this frame.
REQ-015 oSTATE  out  3  encoded state, for LEDs.
REQ-016 oDONE / oOVR / oTMO  out  1 each  frame done; sticky strobe overrun; sticky timeout.

Function
REQ-017 States IDLE=0, ARM=1, CAPTURE=2, SERVE=3, DONE=4; oSTATE shall equal the current encoding.
REQ-018 IDLE->ARM on synchronised iCAP_REQ rising edge; oOVR, oTMO, oWORD_CNT cleared on entry to ARM.
REQ-019 ARM: wait for iFVAL low then high; on that rising edge pulse oSTART one cycle and enter CAPTURE.
REQ-020 CAPTURE: on iFVAL falling edge pulse oEND one cycle and enter SERVE.
REQ-021 SERVE: a synchronised strobe toggle sets a pending flag; pending and !iFIFO_EMPTY asserts oFIFO_RD one cycle; next cycle oDATA<=iFIFO_DATA, oACK toggles, oWORD_CNT increments, pending clears.
REQ-022 Toggle-to-oACK latency shall be 4 cycles (2 sync, 1 pop, 1 latch) with FIFO non-empty.
REQ-023 Pending while FIFO empty: hold pending, no pop, until FIFO non-empty.
REQ-024 Toggle arriving while pending set: ignored, oOVR set sticky.
REQ-025 When oWORD_CNT reaches FRAME_WORDS: enter DONE, oDONE=1; further toggles produce no pop and no oACK change.
REQ-026 DONE->IDLE when synchronised iCAP_REQ low; oDONE cleared on leaving DONE.
REQ-027 iCAP_REQ low in ARM, CAPTURE or SERVE: abort to IDLE next cycle; pulse oEND if aborting from CAPTURE; pending cleared.
REQ-028 oWORD_CNT shall saturate at FRAME_WORDS, never wrap.

Reset
REQ-029 iRST_N low: state IDLE; all outputs 0 including oDATA, oACK, oWORD_CNT, sticky flags; synchroniser flops 0.
REQ-030 Reset mid-frame shall abandon the frame with no oEND pulse; strobe edge reference reloads from synchronised iHPS_STB after release, so no spurious request.

Configuration
REQ-031 FRAME_SEQ_TIMEOUT_EN defined: counter runs in ARM and CAPTURE, clears on state change; reaching TIMEOUT_CYCLES sets oTMO, pulses oEND, returns to IDLE.
REQ-032 FRAME_SEQ_TIMEOUT_EN undefined: no counter, oTMO tied 0, ARM/CAPTURE wait indefinitely.

Structure
REQ-033 Shared package frame_seq_pkg holds state enum encoding and FRAME_WORDS_DEF=19200.
REQ-034 One sub-module sync2 (2-flop synchroniser, async active-low reset) instanced for iCAP_REQ and iHPS_STB.

Verification
REQ-035 Full frame: FRAME_WORDS=4, raise iCAP_REQ, iFVAL 0->1->0, 4 strobe toggles with FIFO non-empty -> one oSTART, one oEND, oACK toggles 4 times, oDATA matches FIFO words, oDONE=1, oWORD_CNT=4.
REQ-036 Empty stall: toggle with iFIFO_EMPTY=1 for 10 cycles -> no oFIFO_RD; deassert empty -> pop next cycle, oACK one cycle later.
REQ-037 Overrun: two toggles 1 cycle apart, FIFO empty -> oOVR=1, exactly one word delivered after empty clears.
REQ-038 Abort: drop iCAP_REQ during CAPTURE -> oEND pulse, oSTATE=0 next cycle, oWORD_CNT=0.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES=100): iFVAL held low in ARM -> oTMO=1 and IDLE at cycle 100; macro off -> still ARM after 1000 cycles.
REQ-040 Reset in SERVE with pending set -> all outputs 0, no oACK toggle after release.
